// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : uart_tx_fifo                                                  |
// | Brief  : UART transmitter with a transmit FIFO; frames go out          |
// |          back-to-back with no idle gap between them.                   |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
module uart_tx_fifo #(
  parameter int CLOCKS_PER_BAUD = 33,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          busy_o,
  output logic                          overflow_o,
  output logic                          frame_done_o,
  output logic                          tx
);

  localparam int                    c_addr_w    = $clog2(FIFO_DEPTH);
  localparam int                    c_baud_w    = $clog2(CLOCKS_PER_BAUD);
  localparam logic [c_baud_w-1:0]   c_baud_max  = c_baud_w'(CLOCKS_PER_BAUD - 1);
  localparam logic [c_addr_w:0]     c_full      = (c_addr_w + 1)'(FIFO_DEPTH);
  localparam logic [2:0]            c_last_bit  = 3'(DATA_BITS - 1);
  localparam logic                  c_last_stop = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                 r_state;
  logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];
  logic [c_addr_w-1:0]    r_wr_ptr;
  logic [c_addr_w-1:0]    r_rd_ptr;
  logic [c_addr_w:0]      r_count;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_parity;
  logic [c_baud_w-1:0]    r_baud_cnt;
  logic [2:0]             r_bit_cnt;
  logic                   r_stop_cnt;
  logic                   r_tx;
  logic                   r_overflow;
  logic                   r_frame_done;

  logic                   w_push;
  logic                   w_pop;
  logic                   w_bit_end;
  logic                   w_frame_end;
  logic [DATA_BITS-1:0]   w_head;

  // Ready depends on current occupancy only, so a full FIFO rejects even when popping.
  assign ready_o     = (r_count != c_full);
  assign w_push      = valid_i && ready_o;
  assign w_bit_end   = (r_baud_cnt == '0);
  assign w_frame_end = (r_state == S_STOP) && w_bit_end && (r_stop_cnt == c_last_stop);
  assign w_pop       = (r_count != '0) && ((r_state == S_IDLE) || w_frame_end);
  assign w_head      = r_mem[r_rd_ptr];

  assign count_o      = r_count;
  assign busy_o       = (r_state != S_IDLE) || (r_count != '0);
  assign overflow_o   = r_overflow;
  assign frame_done_o = r_frame_done;
  assign tx           = r_tx;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_i[DATA_BITS-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= valid_i && !ready_o;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_tx         <= 1'b1;
      r_baud_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_stop_cnt   <= 1'b0;
      r_shift      <= '0;
      r_parity     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      if (w_pop) begin
        // Load covers both the IDLE start and the seamless STOP-to-START handoff.
        r_state    <= S_START;
        r_tx       <= 1'b0;
        r_baud_cnt <= c_baud_max;
        r_shift    <= w_head;
        r_parity   <= (^w_head) ^ (PARITY == 1);
      end else if (r_state == S_IDLE) begin
        r_tx <= 1'b1;
      end else if (!w_bit_end) begin
        r_baud_cnt <= r_baud_cnt - 1'b1;
      end else begin
        r_baud_cnt <= c_baud_max;
        case (r_state)
          S_START: begin
            r_state   <= S_DATA;
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= '0;
          end
          S_DATA: begin
            if (r_bit_cnt == c_last_bit) begin
              if (PARITY != 0) begin
                r_state <= S_PARITY;
                r_tx    <= r_parity;
              end else begin
                r_state    <= S_STOP;
                r_tx       <= 1'b1;
                r_stop_cnt <= 1'b0;
              end
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
          S_PARITY: begin
            r_state    <= S_STOP;
            r_tx       <= 1'b1;
            r_stop_cnt <= 1'b0;
          end
          S_STOP: begin
            if (r_stop_cnt == c_last_stop) begin
              r_state <= S_IDLE;
              r_tx    <= 1'b1;
            end else begin
              r_stop_cnt <= 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_uart_tx_fifo                                               |
// | Brief  : Three frame formats (8N1/4, 7E2/4, 8O1/8) against a queue      |
// |          model of the transmitter. Rev 1.0                             |
// +------------------------------------------------------------------------+
module tb_uart_tx_fifo;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din [3];
  logic       vld [3];
  logic       rdy [3];
  logic       bsy [3];
  logic       ovf [3];
  logic       done [3];
  logic       tx_w [3];
  logic [2:0] cnt0, cnt1;
  logic [3:0] cnt2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLOCKS_PER_BAUD(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .data_i(din[0]), .valid_i(vld[0]), .ready_o(rdy[0]), .count_o(cnt0),
    .busy_o(bsy[0]), .overflow_o(ovf[0]), .frame_done_o(done[0]), .tx(tx_w[0]));
  uart_tx_fifo #(.CLOCKS_PER_BAUD(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .data_i(din[1]), .valid_i(vld[1]), .ready_o(rdy[1]), .count_o(cnt1),
    .busy_o(bsy[1]), .overflow_o(ovf[1]), .frame_done_o(done[1]), .tx(tx_w[1]));
  uart_tx_fifo #(.CLOCKS_PER_BAUD(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .data_i(din[2]), .valid_i(vld[2]), .ready_o(rdy[2]), .count_o(cnt2),
    .busy_o(bsy[2]), .overflow_o(ovf[2]), .frame_done_o(done[2]), .tx(tx_w[2]));

  function automatic int f_db(int k);    return (k == 1) ? 7 : 8; endfunction
  function automatic int f_par(int k);   return (k == 1) ? 2 : ((k == 2) ? 1 : 0); endfunction
  function automatic int f_sb(int k);    return (k == 1) ? 2 : 1; endfunction
  function automatic int f_depth(int k); return (k == 2) ? 8 : 4; endfunction
  function automatic int f_nbits(int k);
    return 1 + f_db(k) + ((f_par(k) != 0) ? 1 : 0) + f_sb(k);
  endfunction

  // Bit idx of a frame carrying byte b: start, data LSB first, optional parity, stops.
  function automatic logic frame_bit(int k, logic [7:0] b, int idx);
    logic [7:0] mask;
    logic       x;
    mask = 8'hFF >> (8 - f_db(k));
    x = ^(b & mask);
    if (idx == 0) return 1'b0;
    if (idx <= f_db(k)) return b[idx-1];
    if (f_par(k) != 0 && idx == f_db(k) + 1) return (f_par(k) == 1) ? ~x : x;
    return 1'b1;
  endfunction

  // Model: a byte queue plus "which cycle of which frame is on the line".
  logic [7:0] m_buf [3][16];
  int         m_head [3] = '{0, 0, 0};
  int         m_cnt [3] = '{0, 0, 0};
  bit         m_busy [3] = '{0, 0, 0};
  int         m_cyc [3] = '{0, 0, 0};
  logic [7:0] m_cur [3];
  bit         e_ovf [3] = '{0, 0, 0};
  bit         e_done [3] = '{0, 0, 0};

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        m_head[k] = 0; m_cnt[k] = 0; m_busy[k] = 0; m_cyc[k] = 0;
        e_ovf[k] = 0; e_done[k] = 0;
      end else begin
        bit fend, pop, push;
        fend = m_busy[k] && (m_cyc[k] == f_nbits(k) * CPB - 1);
        pop  = (!m_busy[k] || fend) && (m_cnt[k] != 0);
        push = vld[k] && (m_cnt[k] < f_depth(k));
        e_ovf[k]  = vld[k] && !push;
        e_done[k] = fend;
        if (fend) m_busy[k] = 0;
        if (m_busy[k]) m_cyc[k]++;
        if (pop) begin
          m_cur[k] = m_buf[k][m_head[k]];
          m_head[k] = (m_head[k] + 1) % 16;
          m_cnt[k]--;
          m_busy[k] = 1;
          m_cyc[k] = 0;
        end
        if (push) begin
          m_buf[k][(m_head[k] + m_cnt[k]) % 16] = din[k];
          m_cnt[k]++;
        end
      end
    end
  end

  // Expected {tx, ready, busy, overflow, frame_done} from model state.
  function automatic logic [4:0] exp_vec(int k);
    logic t;
    t = m_busy[k] ? frame_bit(k, m_cur[k], m_cyc[k] / CPB) : 1'b1;
    return {t, m_cnt[k] < f_depth(k), m_busy[k] || m_cnt[k] != 0, e_ovf[k], e_done[k]};
  endfunction

  function automatic logic [4:0] act_cnt(int k);
    if (k == 0) return {2'b0, cnt0};
    if (k == 1) return {2'b0, cnt1};
    return {1'b0, cnt2};
  endfunction

  task automatic idle_inputs();
    for (int k = 0; k < 3; k++) begin vld[k] = 1'b0; din[k] = 8'h00; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({tx_w[k], rdy[k], bsy[k], ovf[k], done[k]} !== 5'b11000 || act_cnt(k) !== 5'd0) begin
          failures++;
          $display("FAIL reset dut%0d: {tx,rdy,busy,ovf,done}=%b cnt=%0d required 11000 cnt=0",
                   k, {tx_w[k], rdy[k], bsy[k], ovf[k], done[k]}, act_cnt(k));
        end
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_8n1();
    int fall_t = -1, done_t = -1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({tx_w[k], rdy[k], bsy[k], ovf[k], done[k]} !== exp_vec(k) || act_cnt(k) !== 5'(m_cnt[k])) begin
          failures++;
          $display("FAIL 8n1 dut%0d t=%0t: outs=%b cnt=%0d required %b cnt=%0d", k, $time,
                   {tx_w[k], rdy[k], bsy[k], ovf[k], done[k]}, act_cnt(k), exp_vec(k), m_cnt[k]);
        end
      end
      if (fall_t < 0 && tx_w[0] === 1'b0) fall_t = c;
      if (done_t < 0 && done[0] === 1'b1) done_t = c;
      vld[0] = (c == 0);
      din[0] = 8'h55;
    end
    checks++;
    if (fall_t != 2 || done_t - fall_t != 40) begin
      failures++;
      $display("FAIL 8n1_timing: fall at %0d done after %0d, required 2 and 40", fall_t, done_t - fall_t);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3] = '{8'h00, 8'hFF, 8'hA5};
    int fall_t = -1, done_t = -1, peak = 0, ndone = 0;
    for (int c = 0; c < 140; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({tx_w[k], rdy[k], bsy[k], ovf[k], done[k]} !== exp_vec(k) || act_cnt(k) !== 5'(m_cnt[k])) begin
          failures++;
          $display("FAIL b2b dut%0d t=%0t: outs=%b cnt=%0d required %b cnt=%0d", k, $time,
                   {tx_w[k], rdy[k], bsy[k], ovf[k], done[k]}, act_cnt(k), exp_vec(k), m_cnt[k]);
        end
      end
      if (fall_t < 0 && tx_w[0] === 1'b0) fall_t = c;
      if (done[0] === 1'b1) begin done_t = c; ndone++; end
      if (int'(cnt0) > peak) peak = int'(cnt0);
      vld[0] = (c < 3);
      din[0] = bytes[(c < 3) ? c : 0];
    end
    checks++;
    if (done_t - fall_t != 120 || peak != 2 || ndone != 3) begin
      failures++;
      $display("FAIL b2b_span: span=%0d peak=%0d frames=%0d required 120 2 3", done_t - fall_t, peak, ndone);
    end
  endtask

  task automatic test_overflow();
    int novf = 0, ndone = 0;
    for (int c = 0; c < 230; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({tx_w[k], rdy[k], bsy[k], ovf[k], done[k]} !== exp_vec(k) || act_cnt(k) !== 5'(m_cnt[k])) begin
          failures++;
          $display("FAIL overflow dut%0d t=%0t: outs=%b cnt=%0d required %b cnt=%0d", k, $time,
                   {tx_w[k], rdy[k], bsy[k], ovf[k], done[k]}, act_cnt(k), exp_vec(k), m_cnt[k]);
        end
      end
      if (ovf[0] === 1'b1) novf++;
      if (done[0] === 1'b1) ndone++;
      vld[0] = (c < 6);
      din[0] = 8'h31 + 8'(c);
    end
    checks++;
    if (novf != 1 || ndone != 5) begin
      failures++;
      $display("FAIL overflow_count: pulses=%0d frames=%0d required 1 5", novf, ndone);
    end
  endtask

  task automatic test_parity();
    int fall2 = -1;
    logic pbit = 1'bx;
    for (int c = 0; c < 130; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({tx_w[k], rdy[k], bsy[k], ovf[k], done[k]} !== exp_vec(k) || act_cnt(k) !== 5'(m_cnt[k])) begin
          failures++;
          $display("FAIL parity dut%0d t=%0t: outs=%b cnt=%0d required %b cnt=%0d", k, $time,
                   {tx_w[k], rdy[k], bsy[k], ovf[k], done[k]}, act_cnt(k), exp_vec(k), m_cnt[k]);
        end
      end
      if (fall2 < 0 && tx_w[2] === 1'b0) fall2 = c;
      if (fall2 >= 0 && c == fall2 + 9 * CPB + 2) pbit = tx_w[2];
      vld[1] = (c == 0) || (c == 60);
      din[1] = (c == 0) ? 8'h03 : 8'h83;
      vld[2] = (c == 0) || (c == 60);
      din[2] = (c == 0) ? 8'h00 : 8'h01;
    end
    checks++;
    if (pbit !== 1'b1) begin
      failures++;
      $display("FAIL odd_parity_0x00: parity bit %b required 1", pbit);
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 140; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({tx_w[k], rdy[k], bsy[k], ovf[k], done[k]} !== exp_vec(k) || act_cnt(k) !== 5'(m_cnt[k])) begin
          failures++;
          $display("FAIL reset_mid dut%0d t=%0t: outs=%b cnt=%0d required %b cnt=%0d", k, $time,
                   {tx_w[k], rdy[k], bsy[k], ovf[k], done[k]}, act_cnt(k), exp_vec(k), m_cnt[k]);
        end
      end
      if (c == 19) begin
        // Mid data bit 3 of the first frame, two bytes still queued.
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (tx_w[0] !== 1'b1 || cnt0 !== 3'd0 || bsy[0] !== 1'b0) begin
          failures++;
          $display("FAIL async_reset: tx=%b cnt=%0d busy=%b required 1 0 0", tx_w[0], cnt0, bsy[0]);
        end
      end
      if (c == 22) rst_n = 1'b1;
      vld[0] = (c < 3) || (c == 80);
      din[0] = (c == 80) ? 8'h12 : 8'hC0 + 8'(c);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1100; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({tx_w[k], rdy[k], bsy[k], ovf[k], done[k]} !== exp_vec(k) || act_cnt(k) !== 5'(m_cnt[k])) begin
          failures++;
          $display("FAIL random dut%0d t=%0t: outs=%b cnt=%0d required %b cnt=%0d", k, $time,
                   {tx_w[k], rdy[k], bsy[k], ovf[k], done[k]}, act_cnt(k), exp_vec(k), m_cnt[k]);
        end
      end
      for (int k = 0; k < 3; k++) begin
        if (c < 300)      vld[k] = ($urandom_range(0, 2) == 0);
        else if (c < 600) vld[k] = ($urandom_range(0, 39) == 0);
        else              vld[k] = 1'b0;
        din[k] = 8'($urandom);
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_8n1();
    idle_inputs();
    test_back_to_back();
    idle_inputs();
    test_overflow();
    idle_inputs();
    test_parity();
    idle_inputs();
    test_reset_mid();
    idle_inputs();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised next-generation UART transmitter with a built-in transmit FIFO. It has configurable frame format (data bits, parity, stop bits) and an asynchronous active-low reset. It sits between a byte producer (for example a bus-to-serial bridge) and the `tx` pin. The producer can push bursts of bytes without waiting on per-byte done handshakes, and frames go out back-to-back with no idle gap.

## Interface
Parameters:
- `CLOCKS_PER_BAUD`, 33: clock cycles per serial bit; must be ≥ 2.
- `DATA_BITS`, 8: data bits per frame; legal values 5..8.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 16: FIFO entries; power of two, ≥ 2.

Ports:
- `clk`  input  1: the block's single clock; all logic is on the rising edge.
- `rst_n`  input  1: reset, asynchronous and active-low.
- `data_i`  input  8: byte to queue; only bits `[DATA_BITS-1:0]` are transmitted.
- `valid_i`  input  1: push request; accepted on a rising edge where `valid_i && ready_o`.
- `ready_o`  output  1: high when the FIFO is not full.
- `count_o`  output  $clog2(FIFO_DEPTH)+1: FIFO occupancy, excluding the byte held in the shifter.
- `busy_o`  output  1: high when the FSM is not IDLE or `count_o != 0`.
- `overflow_o`  output  1: one-cycle pulse when `valid_i` is high while `ready_o` is low; that byte is dropped.
- `frame_done_o`  output  1: one-cycle pulse on the edge that ends the last stop bit of a frame.
- `tx`  output  1: serial line; idles high.

## Operation
- **Reset** (`rst_n` low, asynchronous):
  - Outputs: `tx`=1, `ready_o`=1, `busy_o`=0, `count_o`=0, `overflow_o`=0, `frame_done_o`=0.
  - Internal: FIFO pointers cleared, FSM in IDLE, baud counter 0.
  - A reset mid-frame aborts the frame immediately, with no clock edge required, and discards all queued bytes.
- **FIFO:**
  - Circular buffer with read/write pointers and an occupancy counter.
  - Push: on `valid_i && ready_o`.
  - Pop: by the FSM when it loads the shifter.
  - Push and pop on the same edge: `count_o` is unchanged.
  - A push is never accepted while full, even if a pop happens on the same edge. `ready_o` is computed from current occupancy only.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when `count_o != 0`: pop the head into the shifter, drive `tx`=0, load the baud counter with `CLOCKS_PER_BAUD-1`.
  - Every bit lasts exactly `CLOCKS_PER_BAUD` cycles. The next bit is driven on the edge where the baud counter reaches 0, and the counter is then reloaded.
  - START → DATA: shifts out `DATA_BITS` bits, LSB first.
  - DATA → PARITY if `PARITY != 0`, otherwise DATA → STOP.
    - Even parity bit = XOR of the data bits.
    - Odd parity bit = inverted XOR of the data bits.
  - STOP drives `tx`=1 for `STOP_BITS` bit periods.
  - At the end of STOP, pulse `frame_done_o`, then:
    - If the FIFO is non-empty, pop and go directly to START on the same edge (`tx`=0, no idle gap).
    - Otherwise go to IDLE with `tx`=1.
- **Frame length:** (1 + `DATA_BITS` + (`PARITY`≠0) + `STOP_BITS`) × `CLOCKS_PER_BAUD` cycles.
- Unused upper bits of `data_i` are ignored entirely, including in the parity calculation.

## Timing
- **Latency, empty FIFO and IDLE:** a byte pushed at edge N sets `count_o`=1 after N. At edge N+1 the FSM pops it, `tx` falls, and `count_o` returns to 0.
- **`tx` is registered.** It changes only on rising edges, except for the asynchronous reset.
- **`frame_done_o`** is high for exactly the one cycle following the final stop-bit edge.
- **`overflow_o`** is high for the cycle after the rejected push edge; FIFO contents are unchanged.
- **`count_o`, `ready_o`, `busy_o`** update on the same edge as the push or pop that changes them.
- **Pointer wrap:** at `FIFO_DEPTH` the pointers wrap with no lost or duplicated bytes. Full is `count_o == FIFO_DEPTH`.

## Test plan
- **8N1, `CLOCKS_PER_BAUD`=4:** push 0x55 → `tx` sequence 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles. `tx` falls one edge after acceptance; `frame_done_o` pulses 40 cycles after `tx` falls; `busy_o` is then 0.
- **Back-to-back:** push 0x00, 0xFF, 0xA5 on consecutive cycles → three contiguous frames totalling 120 cycles, with no high gap between the stop bit and the next start bit. `count_o` peaks at 2.
- **Overflow, `FIFO_DEPTH`=4:** push 6 bytes on consecutive cycles. The 6th push sees `ready_o`=0 and `overflow_o` pulses once. Exactly bytes 1–5 are transmitted, in order.
- **7E2 (`DATA_BITS`=7, `PARITY`=2, `STOP_BITS`=2):** push 0x03 → 0 | 1,1,0,0,0,0,0 | parity 0 | 1,1. Pushing 0x83 produces an identical waveform.
- **8O1:** push 0x00 → parity bit 1. Push 0x01 → parity bit 0.
- **Reset mid-frame:** with 2 bytes queued, drop `rst_n` during data bit 3. `tx`=1 and `count_o`=0 immediately, and no frame follows release. A subsequent push of 0x12 transmits correctly.
